// File: rtl/keccak_padder.sv
// SHA-3 input padder: packs 32-bit message words into rate-sized blocks and applies 0x06..0x80 padding.
// Optional KECCAK_PADDER_BYTECOUNT_EN adds a msg_bytes message length counter output.
module keccak_padder #(
    parameter int C_SHA3_SIZE = 256
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               clear,
    input  logic [31:0]                        in_data,
    input  logic                               in_last,
    input  logic [1:0]                         in_bytes,
    input  logic                               in_valid,
    output logic                               in_ready,
    output logic [1600-2*C_SHA3_SIZE-1:0]      block_data,
    output logic                               block_last,
    output logic                               block_valid,
`ifdef KECCAK_PADDER_BYTECOUNT_EN
    output logic [31:0]                        msg_bytes,
`endif
    input  logic                               block_ready
);
    localparam int RATE   = 1600 - 2 * C_SHA3_SIZE;
    localparam int RATE_W = RATE / 32;
    localparam int WCNT_W = $clog2(RATE_W);

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [RATE-1:0]   buf_q, buf_d;
    logic              last_q, last_d;
    logic              beat;
    logic              done;
    logic              wrap;

    // Bytes at or above the valid count become 0x06 followed by zeros.
    function automatic logic [31:0] pad_word(input logic [31:0] d, input logic [1:0] n);
        logic [31:0] w;
        w = d;
        for (int b = 0; b < 4; b++) begin
            if (b == int'(n))
                w[31-8*b -: 8] = 8'h06;
            else if (b > int'(n))
                w[31-8*b -: 8] = 8'h00;
        end
        return w;
    endfunction

    assign in_ready = (state_q == S_FILL);
    assign beat     = in_valid & in_ready;
    assign done     = (state_q == S_FULL) & block_ready;
    assign wrap     = (wcnt_q == WCNT_W'(RATE_W - 1));

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        buf_d   = buf_q;
        last_d  = last_q;
        case (state_q)
            S_FILL: begin
                if (beat) begin
                    if (in_last) begin
                        for (int k = 0; k < RATE_W; k++) begin
                            if (k == int'(wcnt_q))
                                buf_d[RATE-1-32*k -: 32] = pad_word(in_data, in_bytes);
                            else if (k > int'(wcnt_q))
                                buf_d[RATE-1-32*k -: 32] = 32'h0;
                        end
                        // Final-bit marker in the last byte of the block; may share a byte with 0x06.
                        buf_d[7:0] = buf_d[7:0] | 8'h80;
                        last_d  = 1'b1;
                        state_d = S_FULL;
                    end else begin
                        for (int k = 0; k < RATE_W; k++) begin
                            if (k == int'(wcnt_q))
                                buf_d[RATE-1-32*k -: 32] = in_data;
                        end
                        if (wrap) begin
                            last_d  = 1'b0;
                            state_d = S_FULL;
                        end else begin
                            wcnt_d = wcnt_q + 1'b1;
                        end
                    end
                end
            end
            S_FULL: begin
                if (block_ready) begin
                    state_d = S_FILL;
                    wcnt_d  = '0;
                    buf_d   = '0;
                    last_d  = 1'b0;
                end
            end
            default: state_d = S_FILL;
        endcase
        if (clear) begin
            state_d = S_FILL;
            wcnt_d  = '0;
            buf_d   = '0;
            last_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FILL;
            wcnt_q  <= '0;
            buf_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            buf_q   <= buf_d;
            last_q  <= last_d;
        end
    end

    assign block_data  = buf_q;
    assign block_last  = last_q;
    assign block_valid = (state_q == S_FULL);

`ifdef KECCAK_PADDER_BYTECOUNT_EN
    logic [31:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset || clear)
            cnt_q <= '0;
        else if (done && last_q)
            cnt_q <= '0;
        else if (beat)
            cnt_q <= in_last ? cnt_q + {30'b0, in_bytes} : cnt_q + 32'd4;
    end

    assign msg_bytes = cnt_q;
`endif
endmodule

// File: tb/tb_keccak_padder.sv
// Directed bench for keccak_padder (SHA3-256, 34-word rate): vector table for single-word messages
// plus hand sequences for full blocks, backpressure and clear.
module tb_keccak_padder;
    localparam int RATE   = 1088;
    localparam int RATE_W = 34;

    logic            clk = 1'b0;
    logic            reset, clear;
    logic [31:0]     in_data;
    logic            in_last;
    logic [1:0]      in_bytes;
    logic            in_valid, in_ready;
    logic [RATE-1:0] block_data;
    logic            block_last, block_valid, block_ready;
`ifdef KECCAK_PADDER_BYTECOUNT_EN
    logic [31:0]     msg_bytes;
`endif

    int n_cmp = 0;
    int n_err = 0;

    keccak_padder #(.C_SHA3_SIZE(256)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .in_data(in_data), .in_last(in_last), .in_bytes(in_bytes),
        .in_valid(in_valid), .in_ready(in_ready),
        .block_data(block_data), .block_last(block_last), .block_valid(block_valid),
`ifdef KECCAK_PADDER_BYTECOUNT_EN
        .msg_bytes(msg_bytes),
`endif
        .block_ready(block_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish (got timeout, want finish)");
        $fatal(1);
    end

    typedef struct {
        logic [31:0] data;
        logic [1:0]  nbytes;
        logic [31:0] exp_w0;
        logic [31:0] exp_w33;
    } vec_t;

    vec_t vecs[4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] word(input int k);
        logic [RATE-1:0] t;
        t = block_data;
        return t[RATE-1-32*k -: 32];
    endfunction

    function automatic logic [31:0] mid_or(input int lo, input int hi);
        logic [31:0] acc;
        acc = '0;
        for (int k = lo; k <= hi; k++) acc = acc | word(k);
        return acc;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last, input logic [1:0] nb);
        in_data  = d;
        in_last  = last;
        in_bytes = nb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic handshake();
        block_ready = 1'b1;
        tick();
        block_ready = 1'b0;
    endtask

    logic [RATE-1:0] snap;

    initial begin
        vecs[0] = '{32'hDEADBEEF, 2'd0, 32'h06000000, 32'h00000080};
        vecs[1] = '{32'h61FFFFFF, 2'd1, 32'h61060000, 32'h00000080};
        vecs[2] = '{32'h6162ABCD, 2'd2, 32'h61620600, 32'h00000080};
        vecs[3] = '{32'h616263FF, 2'd3, 32'h61626306, 32'h00000080};

        reset = 1'b1; clear = 1'b0; in_data = '0; in_last = 1'b0; in_bytes = '0;
        in_valid = 1'b0; block_ready = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_block_valid", 64'(block_valid), 64'd0);
        check("rst_block_last", 64'(block_last), 64'd0);
        check("rst_block_data_zero", 64'(|block_data), 64'd0);

        // Single-word messages from the table
        for (int i = 0; i < 4; i++) begin
            send(vecs[i].data, 1'b1, vecs[i].nbytes);
            check($sformatf("v%0d_valid", i), 64'(block_valid), 64'd1);
            check($sformatf("v%0d_last", i), 64'(block_last), 64'd1);
            check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd0);
            check($sformatf("v%0d_w0", i), 64'(word(0)), 64'(vecs[i].exp_w0));
            check($sformatf("v%0d_mid", i), 64'(mid_or(1, 32)), 64'd0);
            check($sformatf("v%0d_w33", i), 64'(word(33)), 64'(vecs[i].exp_w33));
`ifdef KECCAK_PADDER_BYTECOUNT_EN
            check($sformatf("v%0d_msg_bytes", i), 64'(msg_bytes), 64'(vecs[i].nbytes));
`endif
            handshake();
            check($sformatf("v%0d_after_valid", i), 64'(block_valid), 64'd0);
            check($sformatf("v%0d_after_ready", i), 64'(in_ready), 64'd1);
        end

        // 135-byte message: markers share the last byte
        for (int i = 0; i < 33; i++) send(32'h01000000 + 32'(i), 1'b0, 2'd0);
        check("m135_not_full", 64'(block_valid), 64'd0);
        send(32'hAABBCCDD, 1'b1, 2'd3);
        check("m135_valid", 64'(block_valid), 64'd1);
        check("m135_last", 64'(block_last), 64'd1);
        check("m135_w0", 64'(word(0)), 64'h01000000);
        check("m135_w32", 64'(word(32)), 64'h01000020);
        check("m135_w33", 64'(word(33)), 64'hAABBCC86);
`ifdef KECCAK_PADDER_BYTECOUNT_EN
        check("m135_msg_bytes", 64'(msg_bytes), 64'd135);
`endif
        handshake();

        // 136-byte message: a full data block then a padding block
        for (int i = 0; i < 34; i++) send(32'h10000000 + 32'(i), 1'b0, 2'd0);
        check("m136_b1_valid", 64'(block_valid), 64'd1);
        check("m136_b1_last", 64'(block_last), 64'd0);
        check("m136_b1_in_ready", 64'(in_ready), 64'd0);
        check("m136_b1_w33", 64'(word(33)), 64'h10000021);
        handshake();
        check("m136_in_ready", 64'(in_ready), 64'd1);
        send(32'h55555555, 1'b1, 2'd0);
        check("m136_b2_last", 64'(block_last), 64'd1);
        check("m136_b2_w0", 64'(word(0)), 64'h06000000);
        check("m136_b2_mid", 64'(mid_or(1, 32)), 64'd0);
        check("m136_b2_w33", 64'(word(33)), 64'h00000080);
`ifdef KECCAK_PADDER_BYTECOUNT_EN
        check("m136_msg_bytes", 64'(msg_bytes), 64'd136);
`endif
        handshake();

        // Backpressure with a stalled word
        for (int i = 0; i < 34; i++) send(32'h20000000 + 32'(i), 1'b0, 2'd0);
        snap = block_data;
        in_data = 32'h12345678; in_last = 1'b0; in_bytes = 2'd0; in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            tick();
            check($sformatf("bp%0d_in_ready", c), 64'(in_ready), 64'd0);
            check($sformatf("bp%0d_valid", c), 64'(block_valid), 64'd1);
            check($sformatf("bp%0d_data_stable", c), 64'(block_data == snap), 64'd1);
        end
        block_ready = 1'b1;
        tick();
        block_ready = 1'b0;
        check("bp_release_in_ready", 64'(in_ready), 64'd1);
        check("bp_release_valid", 64'(block_valid), 64'd0);
        tick();
        in_valid = 1'b0;
        send(32'h0, 1'b1, 2'd0);
        check("bp_w0_stalled_word", 64'(word(0)), 64'h12345678);
        check("bp_w1_pad", 64'(word(1)), 64'h06000000);
        check("bp_w33", 64'(word(33)), 64'h00000080);
`ifdef KECCAK_PADDER_BYTECOUNT_EN
        check("bp_msg_bytes", 64'(msg_bytes), 64'd140);
`endif
        handshake();

        // Clear after 10 words
        for (int i = 0; i < 10; i++) send(32'hC0000000 + 32'(i), 1'b0, 2'd0);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        check("clr10_in_ready", 64'(in_ready), 64'd1);
        check("clr10_valid", 64'(block_valid), 64'd0);
        check("clr10_data_zero", 64'(|block_data), 64'd0);
        send(32'h0, 1'b1, 2'd0);
        check("clr10_empty_w0", 64'(word(0)), 64'h06000000);
        check("clr10_empty_mid", 64'(mid_or(1, 32)), 64'd0);
        check("clr10_empty_w33", 64'(word(33)), 64'h00000080);
`ifdef KECCAK_PADDER_BYTECOUNT_EN
        check("clr10_msg_bytes", 64'(msg_bytes), 64'd0);
`endif

        // Clear together with a block handshake
        clear = 1'b1; block_ready = 1'b1;
        tick();
        clear = 1'b0; block_ready = 1'b0;
        check("clrhs_valid", 64'(block_valid), 64'd0);
        check("clrhs_in_ready", 64'(in_ready), 64'd1);
        check("clrhs_last", 64'(block_last), 64'd0);

        // Clear together with a beat: the word must be dropped
        in_data = 32'hBAD0BAD0; in_last = 1'b1; in_bytes = 2'd2; in_valid = 1'b1; clear = 1'b1;
        tick();
        in_valid = 1'b0; in_last = 1'b0; clear = 1'b0;
        check("clrbeat_valid", 64'(block_valid), 64'd0);
        check("clrbeat_data_zero", 64'(|block_data), 64'd0);
        send(32'h0, 1'b1, 2'd0);
        check("clrbeat_empty_w0", 64'(word(0)), 64'h06000000);
        check("clrbeat_empty_w33", 64'(word(33)), 64'h00000080);
        check("clrbeat_empty_last", 64'(block_last), 64'd1);
        handshake();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
